siteswap_sequencer: RTL

Consumer of a validated siteswap pattern and its ball count. On each beat it plays the pattern: it decides which ball is thrown, at what height, and from which hand. It keeps an 8-slot landing schedule that records which ball lands on each upcoming beat, and it detects collisions and empty-hand faults. Its outputs drive the juggler animation and the audio/feedback paths.

---
 rtl/siteswap_sequencer_if.sv | 30 +++
 rtl/siteswap_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/siteswap_sequencer_if.sv
// Pattern/beat inputs and per-beat throw outputs of the siteswap sequencer.
interface siteswap_sequencer_if #(
   parameter int MAX_LEN = 7
);
   logic                      new_beat;
   logic [MAX_LEN-1:0][2:0]   pattern_in;
   logic [2:0]                pattern_length;
   logic [2:0]                num_balls_in;
   logic                      pattern_valid_in;
   logic                      throw_valid_out;
   logic [2:0]                throw_ball_out;
   logic [2:0]                throw_height_out;
   logic                      throw_hand_out;
   logic [2:0]                beat_index_out;
   logic [7:0]                airborne_mask_out;
   logic                      running_out;
   logic                      error_out;

   modport master (
      output new_beat, pattern_in, pattern_length, num_balls_in, pattern_valid_in,
      input  throw_valid_out, throw_ball_out, throw_height_out, throw_hand_out,
             beat_index_out, airborne_mask_out, running_out, error_out
   );

   modport slave (
      input  new_beat, pattern_in, pattern_length, num_balls_in, pattern_valid_in,
      output throw_valid_out, throw_ball_out, throw_height_out, throw_hand_out,
             beat_index_out, airborne_mask_out, running_out, error_out
   );
endinterface

// File: rtl/siteswap_sequencer.sv
// Plays a ground-state siteswap beat by beat against an 8-slot landing schedule,
// flagging collisions and empty-hand faults.
module siteswap_sequencer #(
   parameter int MAX_LEN = 7,
   parameter int SLOTS   = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   siteswap_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t                  state_q, state_d;
   logic                    pv_q;
   logic [SLOTS-1:0]        sv_q, sv_d;
   logic [SLOTS-1:0][2:0]   sid_q, sid_d;
   logic [MAX_LEN-1:0][2:0] pat_q, pat_d;
   logic [2:0]              len_q, len_d, idx_q, idx_d;
   logic                    hand_q, hand_d;
   logic                    tv_q, tv_d, thand_q, thand_d, err_q, err_d;
   logic [2:0]              tb_q, tb_d, th_q, th_d, bidx_q, bidx_d;
   logic                    load, fault;
   logic [2:0]              h;

   assign load = bus.pattern_valid_in & ~pv_q;
   assign h    = pat_q[idx_q];

   always_comb begin
      state_d = state_q;
      sv_d    = sv_q;
      sid_d   = sid_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      hand_d  = hand_q;
      tv_d    = 1'b0;
      tb_d    = tb_q;
      th_d    = th_q;
      thand_d = thand_q;
      bidx_d  = bidx_q;
      err_d   = err_q;
      fault   = 1'b0;
      if (load) begin
         pat_d  = bus.pattern_in;
         len_d  = bus.pattern_length;
         idx_d  = 3'd0;
         hand_d = 1'b0;
         if (bus.num_balls_in == 3'd0 || bus.pattern_length == 3'd0) begin
            state_d = ERR;
            err_d   = 1'b1;
            sv_d    = '0;
         end else begin
            state_d = RUN;
            err_d   = 1'b0;
            // Ground state: ball k lands k beats from now.
            for (int k = 0; k < SLOTS; k++) begin
               sv_d[k]  = (3'(k) < bus.num_balls_in);
               sid_d[k] = 3'(k);
            end
         end
      end else if (state_q == RUN) begin
         if (!bus.pattern_valid_in) begin
            state_d = IDLE;
            sv_d    = '0;
         end else if (bus.new_beat) begin
            // Collision test uses slot[h] before the shift.
            fault = (h == 3'd0) ? sv_q[0] : (!sv_q[0] || sv_q[h]);
            if (fault) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else begin
               // Time advances on empty beats too, so the schedule always shifts.
               sv_d  = {1'b0, sv_q[SLOTS-1:1]};
               sid_d = {3'd0, sid_q[SLOTS-1:1]};
               if (h != 3'd0) begin
                  sv_d[h - 3'd1]  = 1'b1;
                  sid_d[h - 3'd1] = sid_q[0];
                  tv_d = 1'b1;
                  tb_d = sid_q[0];
               end
               th_d    = h;
               thand_d = hand_q;
               hand_d  = ~hand_q;
               bidx_d  = idx_q;
               idx_d   = (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         pv_q    <= 1'b0;
         sv_q    <= '0;
         sid_q   <= '0;
         pat_q   <= '0;
         len_q   <= 3'd0;
         idx_q   <= 3'd0;
         hand_q  <= 1'b0;
         tv_q    <= 1'b0;
         tb_q    <= 3'd0;
         th_q    <= 3'd0;
         thand_q <= 1'b0;
         bidx_q  <= 3'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pv_q    <= bus.pattern_valid_in;
         sv_q    <= sv_d;
         sid_q   <= sid_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         hand_q  <= hand_d;
         tv_q    <= tv_d;
         tb_q    <= tb_d;
         th_q    <= th_d;
         thand_q <= thand_d;
         bidx_q  <= bidx_d;
         err_q   <= err_d;
      end
   end

   assign bus.throw_valid_out   = tv_q;
   assign bus.throw_ball_out    = tb_q;
   assign bus.throw_height_out  = th_q;
   assign bus.throw_hand_out    = thand_q;
   assign bus.beat_index_out    = bidx_q;
   assign bus.airborne_mask_out = sv_q;
   assign bus.running_out       = (state_q == RUN);
   assign bus.error_out         = err_q;
endmodule
